// File: rtl/alu_result_fifo_if.sv
// alu_result_fifo_if: push/pop handshake and debug bundle for the
// ALU result FIFO. master = ALU issue / consumer side, slave = FIFO.
//   In_*   : upstream push (valid/ready) carrying ALU result, carry, select
//   Rd_*   : downstream show-ahead pop (valid/ready) with head fields
//   Count, Stall_Cnt, Clear_Stall : occupancy and stall debug
interface alu_result_fifo_if #(
    parameter int DATA_W  = 4,
    parameter int SEL_W   = 3,
    parameter int CNT_W   = 3,
    parameter int STALL_W = 8
);
    logic               In_Valid;
    logic               In_Ready;
    logic [DATA_W-1:0]  In_Result;
    logic               In_Carry;
    logic [SEL_W-1:0]   In_Select;
    logic               Rd_Valid;
    logic               Rd_Ready;
    logic [DATA_W-1:0]  Rd_Result;
    logic               Rd_Carry;
    logic               Rd_Zero;
    logic [SEL_W-1:0]   Rd_Select;
    logic [CNT_W-1:0]   Count;
    logic [STALL_W-1:0] Stall_Cnt;
    logic               Clear_Stall;

    modport master (
        output In_Valid, In_Result, In_Carry, In_Select,
        output Rd_Ready, Clear_Stall,
        input  In_Ready, Rd_Valid, Rd_Result, Rd_Carry,
        input  Rd_Zero, Rd_Select, Count, Stall_Cnt
    );

    modport slave (
        input  In_Valid, In_Result, In_Carry, In_Select,
        input  Rd_Ready, Clear_Stall,
        output In_Ready, Rd_Valid, Rd_Result, Rd_Carry,
        output Rd_Zero, Rd_Select, Count, Stall_Cnt
    );
endinterface

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: buffers ALU results {select, carry, zero, result}
// between the ALU issue logic and the write-back / display consumer.
//   Clk, Reset_n : single clock, synchronous active-low reset
//   bus (slave)  : In_* push side, Rd_* show-ahead pop side, debug
//                  Count / Stall_Cnt with Clear_Stall
module alu_result_fifo #(
    parameter int DATA_W  = 4,
    parameter int SEL_W   = 3,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 3,
    parameter int STALL_W = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    alu_result_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic              carry;
        logic              zero;
        logic [DATA_W-1:0] res;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [STALL_W-1:0] r_stall;

    logic   w_full;
    logic   w_empty;
    logic   w_push;
    logic   w_pop;
    logic   w_stall;
    entry_t w_in;
    entry_t w_head;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.In_Valid & ~w_full;
    assign w_pop   = bus.Rd_Ready & ~w_empty;
    assign w_stall = bus.In_Valid & w_full;

    // Carry only carries meaning for the add operation (select 0).
    always_comb begin
        w_in       = '0;
        w_in.sel   = bus.In_Select;
        w_in.carry = (bus.In_Select == '0) ? bus.In_Carry : 1'b0;
        w_in.zero  = (bus.In_Result == '0);
        w_in.res   = bus.In_Result;
    end

    // Head is forced to zero when empty so stale storage never leaks out.
    assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

    assign bus.In_Ready  = ~w_full;
    assign bus.Rd_Valid  = ~w_empty;
    assign bus.Rd_Result = w_head.res;
    assign bus.Rd_Carry  = w_head.carry;
    assign bus.Rd_Zero   = w_head.zero;
    assign bus.Rd_Select = w_head.sel;
    assign bus.Count     = r_count;
    assign bus.Stall_Cnt = r_stall;

    // Storage is not reset; pointers alone define validity.
    always_ff @(posedge Clk) begin
        if (Reset_n && w_push) begin
            r_mem[r_wr_ptr] <= w_in;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Clear wins over the increment; counter sticks at all-ones.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_stall <= '0;
        end else if (bus.Clear_Stall) begin
            r_stall <= '0;
        end else if (w_stall && !(&r_stall)) begin
            r_stall <= r_stall + STALL_W'(1);
        end
    end
endmodule
